// File: rtl/microcode_sequencer.sv
// Microcode sequencer for the 6502 core: dispatches an opcode into a registered-read
// microcode ROM and steps through CONT/BRANCH/JUMP/END microwords with stall, flush and a watchdog.
module microcode_sequencer #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_W    = 10,
    parameter int OPCODE_W  = 8,
    parameter int MAX_STEPS = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [OPCODE_W-1:0]   opcode_in,
    input  logic                  opcode_valid,
    output logic                  opcode_ready,
    input  logic [3:0]            cond_flags,
    input  logic                  stall,
    input  logic                  flush,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [WORD_SIZE-1:0]  rom_word,
    output logic [WORD_SIZE-3:0]  ctrl_out,
    output logic                  ctrl_valid,
    output logic                  done,
    output logic                  fault
);

    localparam int STEP_W = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

    localparam logic [1:0] OP_CONT   = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_END    = 2'b10;
    localparam logic [1:0] OP_JUMP   = 2'b11;

    typedef enum logic {S_IDLE, S_EXEC} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   upc_q, upc_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                fault_q, fault_d;

    logic [1:0]          seq_op;
    logic [1:0]          cond_sel;
    logic [ADDR_W-1:0]   target;
    logic [ADDR_W-1:0]   entry;
    logic [ADDR_W-1:0]   upc_inc;
    logic [ADDR_W-1:0]   next_pc;
    logic                last_step;

    assign seq_op    = rom_word[WORD_SIZE-1 -: 2];
    assign cond_sel  = rom_word[WORD_SIZE-3 -: 2];
    assign target    = rom_word[ADDR_W-1:0];
    // Shift form keeps ADDR_W == OPCODE_W legal (no zero-width replication).
    assign entry     = ADDR_W'(opcode_in) << (ADDR_W - OPCODE_W);
    assign upc_inc   = upc_q + ADDR_W'(1);
    assign last_step = (step_q == STEP_W'(MAX_STEPS - 1));

    assign ctrl_out  = rom_word[WORD_SIZE-3:0];
    assign fault     = fault_q;

    always_comb begin
        next_pc = upc_inc;
        case (seq_op)
            OP_BRANCH: next_pc = cond_flags[cond_sel] ? target : upc_inc;
            OP_JUMP:   next_pc = target;
            default:   next_pc = upc_inc;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        upc_d        = upc_q;
        step_d       = step_q;
        fault_d      = fault_q;
        opcode_ready = 1'b0;
        ctrl_valid   = 1'b0;
        done         = 1'b0;
        rom_addr     = upc_q;

        case (state_q)
            S_IDLE: begin
                opcode_ready = 1'b1;
                rom_addr     = entry;
                if (opcode_valid) begin
                    state_d = S_EXEC;
                    upc_d   = entry;
                    step_d  = '0;
                end
            end
            S_EXEC: begin
                if (stall) begin
                    // Re-present upc so the ROM keeps returning the same word.
                    rom_addr = upc_q;
                end else if (seq_op == OP_END) begin
                    ctrl_valid = 1'b1;
                    done       = 1'b1;
                    rom_addr   = upc_q;
                    state_d    = S_IDLE;
                end else begin
                    rom_addr = next_pc;
                    upc_d    = next_pc;
                    if (last_step) begin
                        fault_d = 1'b1;
                        state_d = S_IDLE;
                        step_d  = '0;
                    end else begin
                        ctrl_valid = (seq_op == OP_CONT);
                        step_d     = step_q + STEP_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d    = S_IDLE;
            upc_d      = '0;
            step_d     = '0;
            fault_d    = 1'b0;
            ctrl_valid = 1'b0;
            done       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            upc_q   <= '0;
            step_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            step_q  <= step_d;
            fault_q <= fault_d;
        end
    end

endmodule
